// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared reset/NOP defaults and fetch FSM state encoding
package if_fetch_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;
endpackage

// File: rtl/if_pc_next.sv
// if_pc_next: next fetch PC select (hold / +4 / word-aligned redirect)
module if_pc_next (
  input  logic [31:0] pc,
  input  logic        advance,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_next
);
  // redirect wins; masking the low bits keeps every fetch word aligned
  always_comb pc_next = redirect_en ? (redirect_pc & ~32'd3) : advance ? pc + 32'd4 : pc;
endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage with single-outstanding IMEM handshake and squash
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_PC,
  output logic [31:0] if_instr,
  output logic        if_valid
);
  state_t      state, state_next;
  logic [31:0] pc_q, pc_next, hold_pc, hold_instr;
  logic        in_fetch, in_hold, got, deliver_fetch, deliver_hold, capture, advance;

  assign in_fetch      = state == FETCH;
  assign in_hold       = state == HOLD;
  assign got           = in_fetch & imem_rvalid;
  assign deliver_fetch = got & ~stall & ~redirect_en;
  assign deliver_hold  = in_hold & ~stall & ~redirect_en;
  assign capture       = got & stall & ~redirect_en;
  assign advance       = deliver_fetch | deliver_hold;
  assign imem_addr     = pc_q;

  if_pc_next u_pc_next (
    .pc         (pc_q),
    .advance    (advance),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .pc_next    (pc_next)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_next;

  // next state; a redirect with a response still owed must drain it, including a stale one already in DRAIN
  always_comb
    state_next = redirect_en ? (((in_fetch || state == DRAIN) && !imem_rvalid) ? DRAIN : FETCH) :
                 state == IDLE ? FETCH :
                 in_fetch ? (capture ? HOLD : FETCH) :
                 in_hold ? (stall ? HOLD : FETCH) :
                 (imem_rvalid ? FETCH : DRAIN);

  // request is a pure function of state so IMEM sees no comb path from inputs
  always_comb imem_req = in_fetch;

  // program counter
  always_ff @(posedge clk or posedge rst)
    if (rst) pc_q <= RESET_PC;
    else pc_q <= pc_next;

  // park a response that arrived while ID was stalled
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hold_pc    <= RESET_PC;
      hold_instr <= NOP_INSTR;
    end else if (capture) begin
      hold_pc    <= pc_q;
      hold_instr <= imem_rdata;
    end

  // IF/ID outputs: deliver, else bubble unless stalled (redirect always bubbles)
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      if_PC    <= RESET_PC;
      if_instr <= NOP_INSTR;
      if_valid <= 1'b0;
    end else if (deliver_fetch) begin
      if_PC    <= pc_q;
      if_instr <= imem_rdata;
      if_valid <= 1'b1;
    end else if (deliver_hold) begin
      if_PC    <= hold_pc;
      if_instr <= hold_instr;
      if_valid <= 1'b1;
    end else if (redirect_en || !stall) begin
      if_instr <= NOP_INSTR;
      if_valid <= 1'b0;
    end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed, table-driven and random checks of if_fetch against a program-order model
module tb_if_fetch;
  import if_fetch_pkg::*;

  logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, redirect_en = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] redirect_pc = 32'h0, imem_rdata = 32'hDEAD_BEEF;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, if_PC, if_instr;

  if_fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_PC(if_PC), .if_instr(if_instr), .if_valid(if_valid)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // IMEM: word at address a is ~a; one outstanding request, latency lat_fix or random 1..4
  int          lat_fix = 1, cnt = 0;
  bit          outst = 1'b0;
  logic [31:0] m_addr = 32'h0;
  logic [31:0] acc_q[$];
  always @(negedge clk) begin
    if (rst) begin
      outst = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
    end else begin
      if (imem_rvalid) begin
        imem_rvalid = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        outst = 1'b0;
      end else if (outst) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata = ~m_addr;
        end
      end
      if (!outst && imem_req) begin
        outst = 1'b1;
        m_addr = imem_addr;
        cnt = lat_fix > 0 ? lat_fix : int'($urandom_range(1, 4));
        acc_q.push_back(imem_addr);
      end
    end
  end

  // program-order model: each new instruction is the next sequential word or a redirect target
  logic        p_stall, p_redir, prev_valid;
  logic [31:0] p_tgt, exp_pc, prev_pc, prev_instr;
  int          delivered = 0;
  always @(posedge clk) begin
    p_stall = stall;
    p_redir = redirect_en;
    p_tgt = redirect_pc;
  end
  always @(negedge clk) begin
    if (rst) exp_pc = RESET_PC_DEF;
    else if (p_redir) begin
      chk("squash_valid", 32'(if_valid), 0);
      chk("squash_instr", if_instr, NOP_INSTR_DEF);
      chk("squash_pc", if_PC, prev_pc);
      exp_pc = p_tgt & ~32'd3;
    end else if (p_stall) begin
      chk("stall_valid", 32'(if_valid), 32'(prev_valid));
      chk("stall_pc", if_PC, prev_pc);
      chk("stall_instr", if_instr, prev_instr);
    end else if (if_valid) begin
      chk("order_pc", if_PC, exp_pc);
      chk("order_instr", if_instr, ~exp_pc);
      exp_pc = exp_pc + 32'd4;
      delivered++;
    end else begin
      chk("bubble_instr", if_instr, NOP_INSTR_DEF);
      chk("bubble_pc", if_PC, prev_pc);
    end
    prev_valid = if_valid;
    prev_pc = if_PC;
    prev_instr = if_instr;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stall = 1'b0;
    redirect_en = 1'b0;
    step();
    step();
    acc_q.delete();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [31:0] tgt;
    logic [31:0] addr;
    logic [31:0] nxt;
  } rd_t;
  rd_t tab[5];

  initial begin
    int n0, n1, d0;
    tab[0] = '{32'h0000_4003, 32'h0000_4000, 32'h0000_4004};
    tab[1] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
    tab[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000};
    tab[3] = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0004};
    tab[4] = '{32'h1234_567A, 32'h1234_5678, 32'h1234_567C};

    step();
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_pc", if_PC, 32'h0000_3000);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_valid", 32'(if_valid), 0);

    // back-to-back single-cycle IMEM
    lat_fix = 1;
    acc_q.delete();
    rst = 1'b0;
    for (int i = 0; i < 50 && !imem_rvalid; i++) step();
    chk("first_rvalid", 32'(imem_rvalid), 1);
    chk("valid_before", 32'(if_valid), 0);
    step();
    chk("valid_after", 32'(if_valid), 1);
    chk("first_pc", if_PC, 32'h0000_3000);
    for (int i = 0; i < 50 && acc_q.size() < 3; i++) step();
    chk("acc_count", 32'(acc_q.size() >= 3), 1);
    if (acc_q.size() >= 3) begin
      chk("addr0", acc_q[0], 32'h0000_3000);
      chk("addr1", acc_q[1], 32'h0000_3004);
      chk("addr2", acc_q[2], 32'h0000_3008);
    end

    // stall lands with the 3004 response
    do_reset();
    for (int i = 0; i < 50 && !(imem_rvalid && imem_rdata == ~32'h3004); i++) step();
    chk("rv3004", 32'(imem_rvalid), 1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_req", 32'(imem_req), 0);
      chk("hold_pc", if_PC, 32'h0000_3000);
      chk("hold_valid", 32'(if_valid), 0);
    end
    stall = 1'b0;
    step();
    chk("rel_pc", if_PC, 32'h0000_3004);
    chk("rel_valid", 32'(if_valid), 1);
    chk("rel_req", 32'(imem_req), 1);
    chk("rel_addr", imem_addr, 32'h0000_3008);
    step();
    chk("once_valid", 32'(if_valid), 0);

    // redirect while a 3-cycle fetch is outstanding
    do_reset();
    lat_fix = 3;
    for (int i = 0; i < 50 && !(acc_q.size() >= 2 && outst && !imem_rvalid); i++) step();
    chk("outst", 32'(outst), 1);
    redirect_en = 1'b1;
    redirect_pc = 32'h0000_4003;
    n0 = acc_q.size();
    step();
    redirect_en = 1'b0;
    chk("drain_req", 32'(imem_req), 0);
    for (int i = 0; i < 50 && acc_q.size() == n0; i++) begin
      chk("drain_bubble", 32'(if_valid), 0);
      step();
    end
    chk("drain_addr", acc_q[$], 32'h0000_4000);
    for (int i = 0; i < 50 && !if_valid; i++) step();
    chk("drain_pc", if_PC, 32'h0000_4000);
    chk("drain_instr", if_instr, ~32'h0000_4000);

    // redirect in the same cycle as a response
    lat_fix = 2;
    for (int i = 0; i < 50 && !imem_rvalid; i++) step();
    chk("same_rv", 32'(imem_rvalid), 1);
    redirect_en = 1'b1;
    redirect_pc = 32'h0000_5000;
    n0 = acc_q.size();
    step();
    redirect_en = 1'b0;
    chk("same_valid", 32'(if_valid), 0);
    chk("same_cnt", acc_q.size(), n0 + 1);
    chk("same_addr", acc_q[$], 32'h0000_5000);

    // table of redirect targets: alignment and wrap of the following fetch
    lat_fix = 1;
    foreach (tab[k]) begin
      step();
      step();
      redirect_en = 1'b1;
      redirect_pc = tab[k].tgt;
      n0 = acc_q.size();
      step();
      redirect_en = 1'b0;
      for (int i = 0; i < 50 && acc_q.size() == n0; i++) step();
      chk("tab_addr", acc_q[$], tab[k].addr);
      n1 = acc_q.size();
      for (int i = 0; i < 50 && !if_valid; i++) step();
      chk("tab_pc", if_PC, tab[k].addr);
      for (int i = 0; i < 50 && acc_q.size() == n1; i++) step();
      chk("tab_next", acc_q.size() > n1 ? acc_q[n1] : 32'hxxxx_xxxx, tab[k].nxt);
    end

    // asynchronous reset while holding the 3008 word
    do_reset();
    for (int i = 0; i < 50 && !(imem_rvalid && imem_rdata == ~32'h3008); i++) step();
    chk("rv3008", 32'(imem_rvalid), 1);
    stall = 1'b1;
    step();
    chk("h2_req", 32'(imem_req), 0);
    chk("h2_pc", if_PC, 32'h0000_3004);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(if_valid), 0);
    chk("arst_pc", if_PC, 32'h0000_3000);
    chk("arst_instr", if_instr, 32'h0);
    chk("arst_req", 32'(imem_req), 0);
    step();
    step();
    stall = 1'b0;
    n0 = acc_q.size();
    rst = 1'b0;
    for (int i = 0; i < 50 && acc_q.size() == n0; i++) step();
    chk("arst_first", acc_q.size() > n0 ? acc_q[n0] : 32'hxxxx_xxxx, 32'h0000_3000);

    // random stalls, redirects and latencies
    do_reset();
    lat_fix = 0;
    d0 = delivered;
    for (int c = 0; c < 3000; c++) begin
      stall = $urandom_range(0, 3) == 0;
      redirect_en = $urandom_range(0, 11) == 0;
      redirect_pc = $urandom_range(0, 3) == 0 ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      step();
    end
    stall = 1'b0;
    redirect_en = 1'b0;
    chk("progress", 32'(delivered - d0 >= 100), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
